// File: rtl/uart_msg_tx.sv
// ============================================================================
// Module   : uart_msg_tx
// Purpose  : Fixed-message UART transmitter with built-in bit serialiser,
//            one-shot or auto-repeat, configurable parity/stop/gap framing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_msg_tx #(
    parameter int                   CLK_HZ        = 100_000_000,
    parameter int                   BAUD          = 9600,
    parameter int                   MSG_LEN       = 15,
    parameter logic [8*MSG_LEN-1:0] MSG           = "hitsz2024311278",
    parameter int                   PARITY        = 0,
    parameter int                   STOP_BITS     = 1,
    parameter int                   GAP_BITS      = 0,
    parameter int                   REPEAT_CYCLES = 20_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic       abort,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] char_idx
);

    localparam int c_cpb   = CLK_HZ / BAUD;
    localparam int c_cnt_w = (c_cpb > 1) ? $clog2(c_cpb) : 1;
    localparam int c_rep_w = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(c_cpb - 1);
    localparam logic [c_rep_w-1:0] c_rep_last  = c_rep_w'(REPEAT_CYCLES - 1);
    localparam logic [3:0]         c_stop_last = 4'(STOP_BITS - 1);
    localparam logic [3:0]         c_gap_last  = 4'(GAP_BITS - 1);
    localparam logic [7:0]         c_last_char = 8'(MSG_LEN - 1);
    localparam logic               c_odd       = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_GAP, S_RWAIT
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic [c_rep_w-1:0]   r_rep, w_rep_nxt;
    logic [3:0]           r_idx, w_idx_nxt;
    logic [7:0]           r_sh, w_sh_nxt;
    logic                 r_par, w_par_nxt;
    logic                 r_abort, w_abort_nxt;
    logic [7:0]           w_char_nxt;
    logic                 w_tx_nxt, w_busy_nxt, w_done_nxt;
    logic                 w_bit_end, w_eoc, w_load, w_abort_any;
    logic [8*MSG_LEN-1:0] w_msg_sh;

    assign w_bit_end   = (r_cnt == c_bit_last);
    assign w_abort_any = r_abort | abort;
    assign w_msg_sh    = MSG >> {w_char_nxt, 3'b000};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rep_nxt   = r_rep;
        w_idx_nxt   = r_idx;
        w_sh_nxt    = r_sh;
        w_par_nxt   = r_par;
        w_abort_nxt = r_abort | (busy & abort);
        w_char_nxt  = char_idx;
        w_busy_nxt  = busy;
        w_done_nxt  = 1'b0;
        w_eoc       = 1'b0;
        w_load      = 1'b0;

        if (r_state != S_IDLE && r_state != S_RWAIT) begin
            w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_START;
                    w_char_nxt  = 8'd0;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = 4'd0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_sh_nxt = {1'b0, r_sh[7:1]};
                    if (r_idx == 4'd7) begin
                        w_idx_nxt   = 4'd0;
                        w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            S_PAR: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_idx_nxt   = 4'd0;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_idx == c_stop_last) begin
                        w_idx_nxt = 4'd0;
                        if (GAP_BITS != 0) w_state_nxt = S_GAP;
                        else               w_eoc       = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            S_GAP: begin
                if (w_bit_end) begin
                    if (r_idx == c_gap_last) begin
                        w_idx_nxt = 4'd0;
                        w_eoc     = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            S_RWAIT: begin
                if (!mode || abort) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (r_rep == c_rep_last) begin
                    w_state_nxt = S_START;
                    w_rep_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_load      = 1'b1;
                end else begin
                    w_rep_nxt = r_rep + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // End of a character: abort beats everything, then next char, then done.
        if (w_eoc) begin
            if (w_abort_any) begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_char_nxt  = 8'd0;
            end else if (char_idx < c_last_char) begin
                w_char_nxt  = char_idx + 8'd1;
                w_state_nxt = S_START;
                w_load      = 1'b1;
            end else begin
                w_done_nxt = 1'b1;
                w_char_nxt = 8'd0;
                w_rep_nxt  = '0;
                if (mode) begin
                    w_state_nxt = S_RWAIT;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
        end

        if (w_load) begin
            w_sh_nxt  = w_msg_sh[7:0];
            w_par_nxt = (^w_msg_sh[7:0]) ^ c_odd;
        end

        if (w_state_nxt == S_IDLE) w_abort_nxt = 1'b0;

        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_sh_nxt[0];
            S_PAR:   w_tx_nxt = w_par_nxt;
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rep    <= '0;
            r_idx    <= 4'd0;
            r_sh     <= 8'd0;
            r_par    <= 1'b0;
            r_abort  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            char_idx <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rep    <= w_rep_nxt;
            r_idx    <= w_idx_nxt;
            r_sh     <= w_sh_nxt;
            r_par    <= w_par_nxt;
            r_abort  <= w_abort_nxt;
            tx       <= w_tx_nxt;
            busy     <= w_busy_nxt;
            done     <= w_done_nxt;
            char_idx <= w_char_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_msg_tx.sv
// ============================================================================
// Module   : tb_uart_msg_tx
// Purpose  : Directed self-checking bench for uart_msg_tx (CPB = 10, "hi").
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_msg_tx;

    logic       clk = 1'b0;
    logic       rst_n, start, start_b, mode, abort;
    logic       tx_a, busy_a, done_a, tx_b, busy_b, done_b;
    logic [7:0] idx_a, idx_b;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    // Byte 0 (0x68 'h') lives in the low byte so it is sent first.
    uart_msg_tx #(
        .CLK_HZ(1000), .BAUD(100), .MSG_LEN(2), .MSG(16'h6968),
        .PARITY(0), .STOP_BITS(1), .GAP_BITS(0), .REPEAT_CYCLES(50)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
        .tx(tx_a), .busy(busy_a), .done(done_a), .char_idx(idx_a)
    );

    uart_msg_tx #(
        .CLK_HZ(1000), .BAUD(100), .MSG_LEN(2), .MSG(16'h6968),
        .PARITY(1), .STOP_BITS(2), .GAP_BITS(1), .REPEAT_CYCLES(50)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode), .abort(abort),
        .tx(tx_b), .busy(busy_b), .done(done_b), .char_idx(idx_b)
    );

    function automatic logic exp_a(input logic [7:0] ch, input int i);
        if (i == 0)      return 1'b0;
        else if (i <= 8) return ch[i-1];
        else             return 1'b1;
    endfunction

    function automatic logic exp_b(input logic [7:0] ch, input int i);
        if (i == 0)      return 1'b0;
        else if (i <= 8) return ch[i-1];
        else if (i == 9) return ^ch;
        else             return 1'b1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        n_checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || idx_a !== 8'd0 ||
            tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0 || idx_b !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: a tx/busy/done/idx=%b/%b/%b/%0d b=%b/%b/%b/%0d expected 1/0/0/0",
                     tx_a, busy_a, done_a, idx_a, tx_b, busy_b, done_b, idx_b);
        end
    endtask

    task automatic test_plain_frames;
        int bad;
        logic [7:0] ch;
        start = 1'b1;
        tick;
        start = 1'b0;
        n_checks++;
        if (tx_a !== 1'b0 || busy_a !== 1'b1 || idx_a !== 8'd0) begin
            n_fail++;
            $display("FAIL accept: tx=%b busy=%b idx=%0d expected 0 1 0", tx_a, busy_a, idx_a);
        end
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            ch = (k < 100) ? 8'h68 : 8'h69;
            if (tx_a !== exp_a(ch, (k / 10) % 10)) bad++;
            if (k % 10 == 9) begin
                n_checks++;
                if (bad != 0) begin
                    n_fail++;
                    $display("FAIL plain_bit%0d: %0d wrong samples, expected bit %b",
                             k / 10, bad, exp_a(ch, (k / 10) % 10));
                end
                bad = 0;
            end
            if (k == 50 || k == 150) begin
                n_checks++;
                if (idx_a !== 8'(k / 100)) begin
                    n_fail++;
                    $display("FAIL plain_char_idx: got %0d expected %0d", idx_a, k / 100);
                end
            end
            if (k == 199) begin
                n_checks++;
                if (done_a !== 1'b0 || busy_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL plain_pre_done: done=%b busy=%b expected 0 1", done_a, busy_a);
                end
            end
            tick;
        end
        n_checks++;
        if (done_a !== 1'b1 || idx_a !== 8'd0 || tx_a !== 1'b1) begin
            n_fail++;
            $display("FAIL plain_done: done=%b idx=%0d tx=%b expected 1 0 1", done_a, idx_a, tx_a);
        end
        tick;
        n_checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL plain_after_done: done=%b busy=%b expected 0 0", done_a, busy_a);
        end
        repeat (10) tick;
    endtask

    task automatic test_parity_frames;
        int bad;
        logic [7:0] ch;
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        bad = 0;
        for (int k = 0; k < 260; k++) begin
            ch = (k < 130) ? 8'h68 : 8'h69;
            if (tx_b !== exp_b(ch, (k / 10) % 13)) bad++;
            if (k % 10 == 9) begin
                n_checks++;
                if (bad != 0) begin
                    n_fail++;
                    $display("FAIL parity_bit%0d: %0d wrong samples, expected bit %b",
                             k / 10, bad, exp_b(ch, (k / 10) % 13));
                end
                bad = 0;
            end
            tick;
        end
        n_checks++;
        if (done_b !== 1'b1 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_done: done=%b busy=%b expected 1 0", done_b, busy_b);
        end
        repeat (5) tick;
    endtask

    task automatic test_repeat;
        int bad;
        mode  = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (200) tick;
        n_checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b1 || idx_a !== 8'd0) begin
            n_fail++;
            $display("FAIL repeat_done: done=%b busy=%b idx=%0d expected 1 1 0", done_a, busy_a, idx_a);
        end
        bad = 0;
        for (int k = 200; k < 250; k++) begin
            if (tx_a !== 1'b1 || busy_a !== 1'b1) bad++;
            tick;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL repeat_gap: %0d samples not idle-high/busy, expected 0", bad);
        end
        n_checks++;
        if (tx_a !== 1'b0 || idx_a !== 8'd0 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL repeat_restart: tx=%b idx=%0d busy=%b expected 0 0 1", tx_a, idx_a, busy_a);
        end
        repeat (200) tick;
        n_checks++;
        if (done_a !== 1'b1) begin
            n_fail++;
            $display("FAIL repeat_done2: done=%b expected 1", done_a);
        end
        tick;
        mode = 1'b0;
        tick;
        n_checks++;
        if (busy_a !== 1'b0 || tx_a !== 1'b1) begin
            n_fail++;
            $display("FAIL repeat_mode_drop: busy=%b tx=%b expected 0 1", busy_a, tx_a);
        end
        repeat (5) tick;
    endtask

    task automatic test_abort;
        int bad;
        start = 1'b1;
        tick;
        start = 1'b0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            if (k == 35) abort = 1'b1;
            if (k == 36) abort = 1'b0;
            if (tx_a !== exp_a(8'h68, k / 10)) bad++;
            tick;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL abort_char0: %0d wrong samples, expected 0", bad);
        end
        n_checks++;
        if (busy_a !== 1'b0 || tx_a !== 1'b1 || done_a !== 1'b0 || idx_a !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_stop: busy=%b tx=%b done=%b idx=%0d expected 0 1 0 0",
                     busy_a, tx_a, done_a, idx_a);
        end
        bad = 0;
        for (int k = 100; k < 220; k++) begin
            if (tx_a !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b0) bad++;
            tick;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d samples with activity, expected 0", bad);
        end
    endtask

    task automatic test_back_to_back;
        int bad;
        start = 1'b1;
        tick;
        start = 1'b0;
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            if (k == 55)  start = 1'b1;
            if (k == 56)  start = 1'b0;
            if (k == 150) start = 1'b1;
            if (tx_a !== exp_a((k < 100) ? 8'h68 : 8'h69, (k / 10) % 10)) bad++;
            tick;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL busy_start_ignored: %0d wrong samples, expected 0", bad);
        end
        n_checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b busy=%b expected 1 0", done_a, busy_a);
        end
        tick;
        start = 1'b0;
        n_checks++;
        if (tx_a !== 1'b0 || busy_a !== 1'b1 || idx_a !== 8'd0) begin
            n_fail++;
            $display("FAIL b2b_restart: tx=%b busy=%b idx=%0d expected 0 1 0", tx_a, busy_a, idx_a);
        end
        repeat (210) tick;
    endtask

    task automatic test_async_reset;
        int bad;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (150) tick;
        n_checks++;
        if (tx_a !== 1'b0 || idx_a !== 8'd1 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: tx=%b idx=%0d busy=%b expected 0 1 1", tx_a, idx_a, busy_a);
        end
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || idx_a !== 8'd0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: tx=%b busy=%b idx=%0d done=%b expected 1 0 0 0",
                     tx_a, busy_a, idx_a, done_a);
        end
        #2;
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            tick;
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL post_reset_idle: %0d active samples, expected 0", bad);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        start_b = 1'b0;
        mode    = 1'b0;
        abort   = 1'b0;
        #12;
        test_reset;
        tick;
        rst_n = 1'b1;
        tick;
        test_reset;
        test_plain_frames;
        test_parity_frames;
        test_repeat;
        test_abort;
        test_back_to_back;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_msg_tx.md
Name: uart_msg_tx

Overview:
Parametrised fixed-message UART transmitter with an internal bit-serialiser; no separate UART send block is needed. Sends a compile-time message of MSG_LEN bytes, either once per start request or repeatedly with a programmable inter-message delay. Frame format is configurable: optional parity, 1 or 2 stop bits, and optional idle gap between characters. Sits at board top level, driving the UART TX pin directly; busy/done/char_idx serve status LEDs or a host FSM.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
BAUD, 9600, line rate; CPB = CLK_HZ/BAUD, integer truncated (10416 at defaults)
MSG_LEN, 15, message length in bytes, 1..255
MSG, 120-bit vector of "hitsz2024311278", message bytes, byte k at MSG[8k+7:8k], byte 0 sent first
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
GAP_BITS, 0, idle-high bit times inserted after every character's stop bits, 0..15
REPEAT_CYCLES, 20_000_000, idle-high clock cycles between the end of one message and the start of the next in repeat mode

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
start  in  1  level-sampled request; accepted only in IDLE
mode  in  1  0 = one-shot; 1 = auto-repeat
abort  in  1  stop after the current frame completes
tx  out  1  UART serial line, idle high
busy  out  1  high from the accept cycle until return to IDLE
done  out  1  one-cycle pulse when the last character's stop/gap time ends
char_idx  out  8  index of the character in flight; 0 in IDLE

Behaviour:
- Reset (async, rst_n=0): tx=1, busy=0, done=0, char_idx=0, FSM in IDLE, all counters 0. Asserting reset mid-frame forces tx high immediately.
- States: IDLE, START, DATA, PAR, STOP, GAP, RWAIT. All outputs are registered.
- IDLE: start=1 sampled at edge N -> at edge N+1 the FSM is in START, tx=0, busy=1, char_idx=0. start is ignored in every other state.
- Bit timing: a cycle counter 0..CPB-1 (width $clog2(CPB)) advances the bit at CPB-1. Every bit lasts exactly CPB cycles.
- START (1 bit, tx=0) -> DATA: 8 bits, LSB first, 3-bit index -> PAR when PARITY!=0, else STOP.
- PAR: even parity = XOR of the 8 data bits; odd parity = its inverse.
- STOP: STOP_BITS bit times at tx=1 -> GAP when GAP_BITS!=0, else end-of-char.
- GAP: GAP_BITS bit times at tx=1 -> end-of-char.
- Frame length = (10 + (PARITY!=0) + (STOP_BITS-1) + GAP_BITS) * CPB cycles.
- End-of-char, first matching rule wins:
  - abort latched -> IDLE, busy=0, no done pulse.
  - char_idx < MSG_LEN-1 -> char_idx+1, START on the next cycle; no idle cycle between frames beyond GAP.
  - char_idx == MSG_LEN-1 -> done=1 for 1 cycle, char_idx=0. If mode=1 (sampled this cycle) -> RWAIT; else -> IDLE, busy=0.
- RWAIT: tx=1, busy=1. A counter runs 0..REPEAT_CYCLES-1, then START. mode=0 or abort=1 during RWAIT -> IDLE next cycle, busy=0.
- abort: any cycle it is high while busy sets a sticky flag, cleared on entering IDLE. The current frame always completes, so no truncated frame appears on tx. abort in IDLE has no effect.
- Simultaneous events: abort and last-character end on the same cycle -> abort wins, no done pulse. start with abort in IDLE -> start accepted, abort ignored.
- Message-byte selection is combinational from MSG by char_idx. The shift register loads on entry to START.

Test Plan:
1. CLK_HZ=1000, BAUD=100 (CPB=10), MSG="hi", PARITY=0, mode=0; pulse start -> tx low 1 cycle later. Frames 0x68 then 0x69: bits 0,0,0,0,1,0,1,1,0,1 then 0,1,0,0,1,0,1,1,0,1, each 10 cycles. done pulses at cycle 200 after accept; busy low the next cycle.
2. Same, PARITY=1, STOP_BITS=2, GAP_BITS=1 -> 0x68 frame carries parity bit 1. Each frame spans 13 bit times, 130 cycles.
3. mode=1, REPEAT_CYCLES=50 -> after done, tx stays high exactly 50 cycles, then start bit; char_idx restarts at 0. Drop mode during RWAIT -> IDLE next cycle.
4. Assert abort mid-DATA of char 0 -> char 0 completes fully, tx stays high, busy falls, no done pulse, char 1 never sent.
5. Pulse start while busy -> no effect on tx waveform. Hold start high continuously in mode=0 -> a new message begins 1 cycle after busy falls.
6. Pull rst_n low mid-frame -> tx=1, busy=0, char_idx=0 asynchronously. After release, the block stays idle until start.
